// File: rtl/uart_tx_fifo_buf.sv
// uart_tx_fifo_buf: circular transmit FIFO that drains into a UART.
// Words written by a producer are queued in a 2**ADDR_W deep buffer and handed
// to the transmitter one at a time. Each hand-off is a single-cycle tx_start
// pulse, followed by waiting for tx_busy to rise and then fall again.
// The buffer also reports its fill level, almost-full and full, and keeps a
// sticky overflow flag.
module uart_tx_fifo_buf #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              overflow,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W + 1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] LVL_ONE_C = (ADDR_W + 1)'(32'd1);
    localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]     level_r;
    logic [ADDR_W:0]     level_nxt_s;
    logic                empty_r;
    logic                full_r;
    logic                afull_r;
    logic                overflow_r;
    logic                tx_start_r;
    logic [DATA_W-1:0]   tx_data_r;
    logic                pop_s;
    logic                wr_acc_s;
    logic                ovf_set_s;

    assign wr_ready    = ~full_r;
    assign overflow    = overflow_r;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign almost_full = afull_r;
    assign level       = level_r;

    // Drain FSM next state; a pop is issued only when leaving IDLE.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!tx_busy && !empty_r && !flush) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Write acceptance, overflow detection and next fill level.
    // A write into a full FIFO still goes through when a pop frees the slot in the same cycle.
    always_comb begin
        wr_acc_s  = wr_en && (!full_r || pop_s) && !flush;
        ovf_set_s = wr_en && full_r && !pop_s && !flush;
        if (flush) begin
            level_nxt_s = '0;
        end else if (wr_acc_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE_C;
        end else if (!wr_acc_s && pop_s) begin
            level_nxt_s = level_r - LVL_ONE_C;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Storage array; it needs no reset because the pointers and the level define validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Read and write pointers, which wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
        end
    end

    // Level counter and status flags, registered from the next level so they line up with level.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            afull_r <= 1'b0;
        end else begin
            level_r <= level_nxt_s;
            empty_r <= (level_nxt_s == '0);
            full_r  <= (level_nxt_s == DEPTH_C);
            afull_r <= (level_nxt_s >= AFULL_C);
        end
    end

    // Sticky overflow flag; only reset or flush clear it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end
    end

    // UART hand-off: a one-cycle start pulse, with data held until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
        end else begin
            tx_start_r <= pop_s;
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_buf.sv
// Directed testbench for uart_tx_fifo_buf: a default 8x16 instance driven by a
// simple UART model, plus a small 9-bit x 4 instance driven by hand.
module tb_uart_tx_fifo_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       wr_ready, overflow, tx_start, empty, full, almost_full;
    logic [7:0] tx_data;
    logic [4:0] level;

    logic       s_flush = 1'b0;
    logic       s_wr_en = 1'b0;
    logic [8:0] s_wr_data = 9'h000;
    logic       s_busy = 1'b0;
    logic       s_wr_ready, s_overflow, s_start, s_empty, s_full, s_af;
    logic [8:0] s_data;
    logic [2:0] s_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_q[$];
    bit uart_auto  = 1'b0;
    int busy_len   = 10;
    int busy_cnt   = 0;
    bit start_seen = 1'b0;
    bit prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_buf #(.DATA_W(8), .ADDR_W(4), .AFULL_LVL(12)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .overflow(overflow), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .empty(empty), .full(full),
        .almost_full(almost_full), .level(level)
    );

    uart_tx_fifo_buf #(.DATA_W(9), .ADDR_W(2), .AFULL_LVL(3)) dut_small (
        .clk(clk), .rst(rst), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .wr_ready(s_wr_ready), .overflow(s_overflow), .tx_busy(s_busy),
        .tx_start(s_start), .tx_data(s_data), .empty(s_empty), .full(s_full),
        .almost_full(s_af), .level(s_level)
    );

    // Monitor: records every start pulse and checks it lasts one cycle. Also runs the UART model.
    always @(posedge clk) begin
        #1;
        if (tx_start) begin
            cap_q.push_back(tx_data);
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL start_pulse_width: tx_start high 2 cycles, expected 1");
            end
        end
        prev_start = tx_start;
        if (uart_auto) begin
            if (busy_cnt != 0) begin
                busy_cnt = busy_cnt - 1;
                tx_busy  = (busy_cnt != 0);
            end else if (start_seen) begin
                start_seen = 1'b0;
                tx_busy    = 1'b1;
                busy_cnt   = busy_len;
            end
            if (tx_start) start_seen = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if ({full, almost_full, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {full, almost_full, overflow}); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if ({s_empty, s_level, s_wr_ready} !== 5'b1_000_1) begin errors++; $display("FAIL reset_small: got %b expected 10001", {s_empty, s_level, s_wr_ready}); end
    endtask

    task automatic test_basic();
        cap_q.delete();
        uart_auto = 1'b1;
        wr_en = 1'b1; wr_data = 8'h41;
        tick();
        checks++; if (level !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL basic_first_write: level=%0d empty=%b expected 1/0", level, empty); end
        wr_data = 8'h42;
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL basic_latency: start=%b data=%h expected 1/41", tx_start, tx_data); end
        wr_data = 8'h43;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 100 && cap_q.size() < 3; k++) tick();
        checks++; if (cap_q.size() != 3) begin errors++; $display("FAIL basic_count: got %0d words expected 3", cap_q.size()); end
        else begin
            checks++; if (cap_q[0] !== 8'h41 || cap_q[1] !== 8'h42 || cap_q[2] !== 8'h43) begin errors++; $display("FAIL basic_order: got %h %h %h expected 41 42 43", cap_q[0], cap_q[1], cap_q[2]); end
        end
        checks++; if (empty !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL basic_empty: empty=%b level=%0d expected 1/0", empty, level); end
        repeat (20) tick();
    endtask

    task automatic test_fill_overflow();
        cap_q.delete();
        uart_auto = 1'b0;
        tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            if (i == 10) begin
                checks++; if (almost_full !== 1'b0 || level !== 5'd11) begin errors++; $display("FAIL fill_afull_11: af=%b level=%0d expected 0/11", almost_full, level); end
            end
            if (i == 11) begin
                checks++; if (almost_full !== 1'b1 || level !== 5'd12) begin errors++; $display("FAIL fill_afull_12: af=%b level=%0d expected 1/12", almost_full, level); end
            end
            if (i == 14) begin
                checks++; if (full !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL fill_15: full=%b wr_ready=%b expected 0/1", full, wr_ready); end
            end
            if (i == 15) begin
                checks++; if (full !== 1'b1 || wr_ready !== 1'b0 || level !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL fill_16: full=%b rdy=%b level=%0d ovf=%b expected 1/0/16/0", full, wr_ready, level, overflow); end
            end
        end
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL fill_overflow: ovf=%b level=%0d expected 1/16", overflow, level); end
        tx_busy = 1'b0;
        uart_auto = 1'b1;
        for (int k = 0; k < 400 && cap_q.size() < 16; k++) tick();
        repeat (20) tick();
        checks++; if (cap_q.size() != 16) begin errors++; $display("FAIL fill_drain_count: got %0d expected 16", cap_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (cap_q[i] !== 8'(i)) begin errors++; $display("FAIL fill_drain_word%0d: got %h expected %h", i, cap_q[i], 8'(i)); end
            end
        end
        checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL fill_after: empty=%b ovf=%b expected 1/1", empty, overflow); end
    endtask

    task automatic test_full_write_pop();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (overflow !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL flush_clears_ovf: ovf=%b level=%0d expected 0/0", overflow, level); end
        cap_q.delete();
        uart_auto = 1'b0;
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        checks++; if (full !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL wp_full: full=%b rdy=%b expected 1/0", full, wr_ready); end
        tx_busy = 1'b0;
        uart_auto = 1'b1;
        wr_en = 1'b1; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        checks++; if (level !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL wp_level: level=%0d ovf=%b full=%b expected 16/0/1", level, overflow, full); end
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h50) begin errors++; $display("FAIL wp_pop: start=%b data=%h expected 1/50", tx_start, tx_data); end
        for (int k = 0; k < 450 && cap_q.size() < 17; k++) tick();
        repeat (20) tick();
        checks++; if (cap_q.size() != 17) begin errors++; $display("FAIL wp_count: got %0d expected 17", cap_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (cap_q[i] !== 8'h50 + 8'(i)) begin errors++; $display("FAIL wp_word%0d: got %h expected %h", i, cap_q[i], 8'h50 + 8'(i)); end
            end
            checks++; if (cap_q[16] !== 8'hAA) begin errors++; $display("FAIL wp_last: got %h expected AA", cap_q[16]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wp_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_flush();
        cap_q.delete();
        uart_auto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            tick();
        end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL flush_state: level=%0d empty=%b ovf=%b expected 0/1/0", level, empty, overflow); end
        repeat (40) tick();
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL flush_count: got %0d expected 1", cap_q.size()); end
        else begin
            checks++; if (cap_q[0] !== 8'h60) begin errors++; $display("FAIL flush_inflight: got %h expected 60", cap_q[0]); end
        end
        checks++; if (empty !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL flush_idle: empty=%b busy=%b expected 1/0", empty, tx_busy); end
    endtask

    task automatic test_stream();
        int idx = 0;
        cap_q.delete();
        uart_auto = 1'b1;
        for (int k = 0; k < 3000 && cap_q.size() < 40; k++) begin
            if (wr_ready && idx < 40) begin
                wr_en = 1'b1; wr_data = 8'(idx); idx++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        repeat (20) tick();
        checks++; if (cap_q.size() != 40) begin errors++; $display("FAIL stream_count: got %0d expected 40", cap_q.size()); end
        else begin
            for (int i = 0; i < 40; i++) begin
                checks++; if (cap_q[i] !== 8'(i)) begin errors++; $display("FAIL stream_word%0d: got %h expected %h", i, cap_q[i], 8'(i)); end
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid();
        cap_q.delete();
        uart_auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 20 && !tx_busy; k++) tick();
        repeat (3) tick();
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL rstmid_queued: level=%0d expected 3", level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({tx_start, tx_data} !== 9'h000) begin errors++; $display("FAIL rstmid_tx: start/data=%h expected 000", {tx_start, tx_data}); end
        checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_level: level=%0d empty=%b expected 0/1", level, empty); end
        checks++; if ({full, almost_full, overflow, wr_ready} !== 4'b0001) begin errors++; $display("FAIL rstmid_flags: got %b expected 0001", {full, almost_full, overflow, wr_ready}); end
        repeat (30) tick();
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL rstmid_no_start: got %0d words expected 1", cap_q.size()); end
        wr_en = 1'b1; wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 40 && cap_q.size() < 2; k++) tick();
        checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL rstmid_resume_count: got %0d expected 2", cap_q.size()); end
        else begin
            checks++; if (cap_q[1] !== 8'h99) begin errors++; $display("FAIL rstmid_resume: got %h expected 99", cap_q[1]); end
        end
        repeat (20) tick();
    endtask

    task automatic test_small_cfg();
        logic [8:0] exp_s [4] = '{9'h101, 9'h102, 9'h103, 9'h1FF};
        s_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_wr_en = 1'b1; s_wr_data = 9'h100 + 9'(i);
            tick();
            if (i == 1) begin
                checks++; if (s_af !== 1'b0) begin errors++; $display("FAIL small_af_2: got %b expected 0", s_af); end
            end
            if (i == 2) begin
                checks++; if (s_af !== 1'b1 || s_full !== 1'b0) begin errors++; $display("FAIL small_af_3: af=%b full=%b expected 1/0", s_af, s_full); end
            end
        end
        checks++; if (s_full !== 1'b1 || s_wr_ready !== 1'b0 || s_level !== 3'd4) begin errors++; $display("FAIL small_full: full=%b rdy=%b level=%0d expected 1/0/4", s_full, s_wr_ready, s_level); end
        s_busy = 1'b0; s_wr_data = 9'h1FF;
        tick();
        checks++; if (s_level !== 3'd4 || s_overflow !== 1'b0) begin errors++; $display("FAIL small_wp: level=%0d ovf=%b expected 4/0", s_level, s_overflow); end
        checks++; if (s_start !== 1'b1 || s_data !== 9'h100) begin errors++; $display("FAIL small_first: start=%b data=%h expected 1/100", s_start, s_data); end
        s_wr_data = 9'h0AB; s_busy = 1'b1;
        tick();
        s_wr_en = 1'b0;
        checks++; if (s_overflow !== 1'b1 || s_level !== 3'd4) begin errors++; $display("FAIL small_ovf: ovf=%b level=%0d expected 1/4", s_overflow, s_level); end
        tick();
        s_busy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 10 && !s_start; k++) tick();
            checks++; if (s_start !== 1'b1 || s_data !== exp_s[j]) begin errors++; $display("FAIL small_word%0d: start=%b data=%h expected 1/%h", j, s_start, s_data, exp_s[j]); end
            s_busy = 1'b1;
            tick();
            tick();
            s_busy = 1'b0;
        end
        repeat (5) tick();
        checks++; if (s_empty !== 1'b1 || s_start !== 1'b0) begin errors++; $display("FAIL small_empty: empty=%b start=%b expected 1/0", s_empty, s_start); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_write_pop();
        test_flush();
        test_stream();
        test_reset_mid();
        test_small_cfg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
